// File: rtl/debug_disp_pkg.sv
// Shared types and the hex-to-seven-segment lookup for the debug display path.
package debug_disp_pkg;

  // Segment byte, bit order {dp,g,f,e,d,c,b,a}, active-low.
  typedef logic [7:0] seg_t;

  // All segments and the decimal point off.
  localparam seg_t SEG_BLANK = 8'hFF;

  // Hex digit to segment pattern; the decimal point is always off here.
  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debug_display_mux_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on the rising edge of the accepted level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             pulse_q, pulse_d;

  // Next-state: accept the synchronised level once it has differed from the
  // accepted level for DEBOUNCE_CYC consecutive samples.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pulse_d = level_d & ~level_q;
  end

  // State register. The synchroniser and accepted level come out of reset as
  // "pressed", so a button held through reset must be released and settle
  // before a new press can produce a pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/debug_display_mux.sv
// Debug display multiplexer: picks one of NUM_CH debug words with buttons or
// an auto-rotation timer, optionally freezes it, and scans it as hex onto a
// multiplexed seven-segment display.
module debug_display_mux
  import debug_disp_pkg::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DIGITS       = DATA_W / 4,
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned AUTO_PERIOD  = 100000000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH*DATA_W-1:0]   debug_in,
  input  logic                       btn_next,
  input  logic                       btn_prev,
  input  logic                       auto_en,
  input  logic                       freeze,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic [DIGITS-1:0]          num_an,
  output seg_t                       num_csn
);

  localparam int unsigned CH_W     = $clog2(NUM_CH);
  localparam int unsigned TMR_W    = $clog2(AUTO_PERIOD + 1);
  localparam int unsigned DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SCAN_W   = SCAN_DIV + DIG_W;
  localparam int unsigned SCAN_TOP = DIGITS * (2 ** SCAN_DIV) - 1;

  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(AUTO_PERIOD - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TOP);

  logic              next_p, prev_p;
  logic              auto_step;
  logic [DATA_W-1:0] live_word;
  logic [DIG_W-1:0]  dig_idx;
  logic [3:0]        nib;

  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic              ch_chg_q, ch_chg_d;
  logic [TMR_W-1:0]  tmr_q,    tmr_d;
  logic [DATA_W-1:0] snap_q,   snap_d;
  logic [SCAN_W-1:0] scan_q,   scan_d;
  logic [DIGITS-1:0] an_q,     an_d;
  seg_t              csn_q,    csn_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
    .clk     (clk),
    .resetn  (resetn),
    .btn_raw (btn_next),
    .pulse   (next_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
    .clk     (clk),
    .resetn  (resetn),
    .btn_raw (btn_prev),
    .pulse   (prev_p)
  );

  // Auto timer and channel select; a button pulse restarts the timer and
  // suppresses a coincident terminal count so only one step is taken.
  always_comb begin
    tmr_d     = tmr_q;
    ch_sel_d  = ch_sel_q;
    auto_step = 1'b0;
    if (!auto_en || next_p || prev_p) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_LAST) begin
      tmr_d     = '0;
      auto_step = 1'b1;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if ((next_p && !prev_p) || auto_step) begin
      ch_sel_d = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
    end else if (prev_p && !next_p) begin
      ch_sel_d = (ch_sel_q == '0) ? CH_LAST : ch_sel_q - CH_W'(1);
    end
    ch_chg_d = (ch_sel_d != ch_sel_q);
  end

  // Snapshot: track the selected channel unless frozen; a channel change
  // while frozen forces exactly one reload from the new channel.
  always_comb begin
    live_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel_q == CH_W'(k)) live_word = debug_in[k*DATA_W +: DATA_W];
    end
    snap_d = (!freeze || ch_chg_q) ? live_word : snap_q;
  end

  // Digit scan: enable and segments are computed together and registered on
  // the same edge so the digit switch cannot glitch.
  always_comb begin
    scan_d  = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    dig_idx = scan_q[SCAN_W-1:SCAN_DIV];
    nib     = '0;
    an_d    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == DIG_W'(i)) begin
        an_d[i] = 1'b0;
        nib     = snap_q[4*i +: 4];
      end
    end
    csn_d = hex2seg(nib);
    if (dig_idx == '0 && freeze) csn_d[7] = 1'b0;
  end

  // State register; reset blanks the display and clears every counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ch_sel_q <= '0;
      ch_chg_q <= 1'b0;
      tmr_q    <= '0;
      snap_q   <= '0;
      scan_q   <= '0;
      an_q     <= '1;
      csn_q    <= SEG_BLANK;
    end else begin
      ch_sel_q <= ch_sel_d;
      ch_chg_q <= ch_chg_d;
      tmr_q    <= tmr_d;
      snap_q   <= snap_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      csn_q    <= csn_d;
    end
  end

  assign ch_sel  = ch_sel_q;
  assign num_an  = an_q;
  assign num_csn = csn_q;

endmodule
